// File: rtl/tcdm_req_arbiter.sv
// Round-robin arbiter sharing one TCDM/SoC shim data port between NumReq requesters.
// Allocates shim meta IDs from a free pool and routes out-of-order responses back by ID table.
module tcdm_req_arbiter #(
  parameter int unsigned NumReq              = 2,
  parameter int unsigned AddrWidth           = 32,
  parameter int unsigned DataWidth           = 32,
  parameter int unsigned StrbWidth           = DataWidth / 8,
  parameter int unsigned MaxOutStandingTrans = 8,
  parameter int unsigned MetaIdWidth         = (MaxOutStandingTrans > 1) ? $clog2(MaxOutStandingTrans) : 1,
  parameter int unsigned ReqIdWidth          = 3,
  parameter int unsigned CntWidth            = $clog2(MaxOutStandingTrans + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     in_qaddr_i,
  input  logic [NumReq-1:0]                    in_qwrite_i,
  input  logic [NumReq-1:0][3:0]               in_qamo_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     in_qdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0]     in_qstrb_i,
  input  logic [NumReq-1:0][ReqIdWidth-1:0]    in_qid_i,
  input  logic [NumReq-1:0]                    in_qvalid_i,
  output logic [NumReq-1:0]                    in_qready_o,
  output logic [NumReq-1:0][DataWidth-1:0]     in_pdata_o,
  output logic [NumReq-1:0]                    in_pwrite_o,
  output logic [NumReq-1:0]                    in_perror_o,
  output logic [NumReq-1:0][ReqIdWidth-1:0]    in_pid_o,
  output logic [NumReq-1:0]                    in_pvalid_o,
  input  logic [NumReq-1:0]                    in_pready_i,
  output logic [AddrWidth-1:0]                 out_qaddr_o,
  output logic                                 out_qwrite_o,
  output logic [3:0]                           out_qamo_o,
  output logic [DataWidth-1:0]                 out_qdata_o,
  output logic [StrbWidth-1:0]                 out_qstrb_o,
  output logic [MetaIdWidth-1:0]               out_qid_o,
  output logic                                 out_qvalid_o,
  input  logic                                 out_qready_i,
  input  logic [DataWidth-1:0]                 out_pdata_i,
  input  logic                                 out_pwrite_i,
  input  logic                                 out_perror_i,
  input  logic [MetaIdWidth-1:0]               out_pid_i,
  input  logic                                 out_pvalid_i,
  output logic                                 out_pready_o,
  output logic [CntWidth-1:0]                  outstanding_o,
  output logic                                 id_err_o
);
  // Handshakes: a beat transfers on a cycle where valid && ready; a requester
  // that raised valid holds valid and payload stable until it sees ready.

  localparam int unsigned GntWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e                   r_state;
  logic [GntWidth-1:0]      r_rr_ptr;
  logic [GntWidth-1:0]      r_lock_idx;
  logic [MetaIdWidth-1:0]   r_lock_id;
  logic [MaxOutStandingTrans-1:0] r_valid;
  logic [GntWidth-1:0]      r_owner [MaxOutStandingTrans];
  logic [ReqIdWidth-1:0]    r_rid   [MaxOutStandingTrans];
  logic [CntWidth-1:0]      r_count;

  logic [GntWidth-1:0]      w_scan_idx;
  logic [GntWidth-1:0]      w_rr_gnt;
  logic                     w_rr_found;
  logic [MetaIdWidth-1:0]   w_free_id;
  logic                     w_free_avail;
  logic [GntWidth-1:0]      w_gnt;
  logic [MetaIdWidth-1:0]   w_qid;
  logic                     w_qvalid;
  logic                     w_req_hs;
  logic                     w_pid_ok;
  logic                     w_e_valid;
  logic [GntWidth-1:0]      w_owner;
  logic [ReqIdWidth-1:0]    w_rid;
  logic                     w_rsp_hs;

  // Round-robin scan starting at r_rr_ptr, plus lowest free table entry.
  always_comb begin
    w_scan_idx   = '0;
    w_rr_gnt     = '0;
    w_rr_found   = 1'b0;
    w_free_id    = '0;
    w_free_avail = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      w_scan_idx = GntWidth'((32'(r_rr_ptr) + 32'(k)) % NumReq);
      if (!w_rr_found && in_qvalid_i[w_scan_idx]) begin
        w_rr_gnt   = w_scan_idx;
        w_rr_found = 1'b1;
      end
    end
    for (int i = MaxOutStandingTrans - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_id    = MetaIdWidth'(i);
        w_free_avail = 1'b1;
      end
    end
  end

  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_gnt    = r_lock_idx;
      w_qid    = r_lock_id;
      w_qvalid = in_qvalid_i[r_lock_idx];
    end else begin
      w_gnt    = w_rr_gnt;
      w_qid    = w_free_id;
      w_qvalid = w_rr_found && w_free_avail;
    end
  end

  assign out_qvalid_o = w_qvalid && !rst_i;
  assign w_req_hs     = out_qvalid_o && out_qready_i;
  assign out_qaddr_o  = in_qaddr_i[w_gnt];
  assign out_qwrite_o = in_qwrite_i[w_gnt];
  assign out_qamo_o   = in_qamo_i[w_gnt];
  assign out_qdata_o  = in_qdata_i[w_gnt];
  assign out_qstrb_o  = in_qstrb_i[w_gnt];
  assign out_qid_o    = w_qid;

  always_comb begin
    in_qready_o = '0;
    if (out_qvalid_o) in_qready_o[w_gnt] = out_qready_i;
  end

  // Response routing: lookup by shim meta ID; unknown IDs are sunk and flagged.
  assign w_pid_ok  = (32'(out_pid_i) < MaxOutStandingTrans);
  assign w_e_valid = w_pid_ok && r_valid[out_pid_i];
  assign w_owner   = r_owner[out_pid_i];
  assign w_rid     = r_rid[out_pid_i];

  always_comb begin
    in_pvalid_o = '0;
    in_pid_o    = '0;
    for (int r = 0; r < NumReq; r++) begin
      in_pdata_o[r]  = out_pdata_i;
      in_pwrite_o[r] = out_pwrite_i;
      in_perror_o[r] = out_perror_i;
    end
    if (w_e_valid) in_pid_o[w_owner] = w_rid;
    if (!rst_i && out_pvalid_i && w_e_valid) in_pvalid_o[w_owner] = 1'b1;
  end

  assign out_pready_o  = !rst_i && (w_e_valid ? in_pready_i[w_owner] : 1'b1);
  assign id_err_o      = !rst_i && out_pvalid_i && !w_e_valid;
  assign w_rsp_hs      = !rst_i && out_pvalid_i && w_e_valid && in_pready_i[w_owner];
  assign outstanding_o = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_UNLOCKED;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_lock_id  <= '0;
      r_valid    <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_qvalid && !out_qready_i) begin
            r_lock_idx <= w_gnt;
            r_lock_id  <= w_qid;
            r_state    <= ST_LOCKED;
          end
        end
        ST_LOCKED: if (w_req_hs) r_state <= ST_UNLOCKED;
        default:   r_state <= ST_UNLOCKED;
      endcase
      if (w_req_hs) begin
        r_valid[w_qid] <= 1'b1;
        r_rr_ptr       <= (w_gnt == GntWidth'(NumReq - 1)) ? '0 : w_gnt + 1'b1;
      end
      if (w_rsp_hs) r_valid[out_pid_i] <= 1'b0;
      r_count <= r_count + CntWidth'(w_req_hs) - CntWidth'(w_rsp_hs);
    end
  end

  // Owner/rid are only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (w_req_hs) begin
      r_owner[w_qid] <= w_gnt;
      r_rid[w_qid]   <= in_qid_i[w_gnt];
    end
  end

endmodule

// File: tb/tb_tcdm_req_arbiter.sv
// Bench for tcdm_req_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a pool/ownership reference model.
module tb_tcdm_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MO = 8;
  localparam int MW = 3;
  localparam int RW = 3;
  localparam int CW = 4;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [N-1:0][AW-1:0]   in_qaddr_i;
  logic [N-1:0]           in_qwrite_i;
  logic [N-1:0][3:0]      in_qamo_i;
  logic [N-1:0][DW-1:0]   in_qdata_i;
  logic [N-1:0][SW-1:0]   in_qstrb_i;
  logic [N-1:0][RW-1:0]   in_qid_i;
  logic [N-1:0]           in_qvalid_i;
  logic [N-1:0]           in_qready_o;
  logic [N-1:0][DW-1:0]   in_pdata_o;
  logic [N-1:0]           in_pwrite_o;
  logic [N-1:0]           in_perror_o;
  logic [N-1:0][RW-1:0]   in_pid_o;
  logic [N-1:0]           in_pvalid_o;
  logic [N-1:0]           in_pready_i;
  logic [AW-1:0]          out_qaddr_o;
  logic                   out_qwrite_o;
  logic [3:0]             out_qamo_o;
  logic [DW-1:0]          out_qdata_o;
  logic [SW-1:0]          out_qstrb_o;
  logic [MW-1:0]          out_qid_o;
  logic                   out_qvalid_o;
  logic                   out_qready_i;
  logic [DW-1:0]          out_pdata_i;
  logic                   out_pwrite_i;
  logic                   out_perror_i;
  logic [MW-1:0]          out_pid_i;
  logic                   out_pvalid_i;
  logic                   out_pready_o;
  logic [CW-1:0]          outstanding_o;
  logic                   id_err_o;

  tcdm_req_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_qaddr_i(in_qaddr_i), .in_qwrite_i(in_qwrite_i), .in_qamo_i(in_qamo_i),
    .in_qdata_i(in_qdata_i), .in_qstrb_i(in_qstrb_i), .in_qid_i(in_qid_i),
    .in_qvalid_i(in_qvalid_i), .in_qready_o(in_qready_o),
    .in_pdata_o(in_pdata_o), .in_pwrite_o(in_pwrite_o), .in_perror_o(in_perror_o),
    .in_pid_o(in_pid_o), .in_pvalid_o(in_pvalid_o), .in_pready_i(in_pready_i),
    .out_qaddr_o(out_qaddr_o), .out_qwrite_o(out_qwrite_o), .out_qamo_o(out_qamo_o),
    .out_qdata_o(out_qdata_o), .out_qstrb_o(out_qstrb_o), .out_qid_o(out_qid_o),
    .out_qvalid_o(out_qvalid_o), .out_qready_i(out_qready_i),
    .out_pdata_i(out_pdata_i), .out_pwrite_i(out_pwrite_i), .out_perror_i(out_perror_i),
    .out_pid_i(out_pid_i), .out_pvalid_i(out_pvalid_i), .out_pready_o(out_pready_o),
    .outstanding_o(outstanding_o), .id_err_o(id_err_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    in_qaddr_i   = '0;
    in_qwrite_i  = '0;
    in_qamo_i    = '0;
    in_qdata_i   = '0;
    in_qstrb_i   = '0;
    in_qid_i     = '0;
    in_qvalid_i  = '0;
    in_pready_i  = '1;
    out_qready_i = 1'b0;
    out_pdata_i  = 32'hCAFE;
    out_pwrite_i = 1'b0;
    out_perror_i = 1'b0;
    out_pid_i    = '0;
    out_pvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [AW-1:0] a, input logic [RW-1:0] id);
    in_qvalid_i[r] = v;
    in_qaddr_i[r]  = a;
    in_qdata_i[r]  = ~a;
    in_qid_i[r]    = id;
  endtask

  task automatic set_rsp(input logic v, input logic [MW-1:0] pid, input logic [N-1:0] rdy);
    out_pvalid_i = v;
    out_pid_i    = pid;
    in_pready_i  = rdy;
  endtask

  // Directed vector table
  typedef struct {
    logic        rst;
    logic [1:0]  qv;
    logic [2:0]  qid0, qid1;
    logic        qrdy;
    logic        pv;
    logic [2:0]  pid;
    logic [1:0]  prdy;
    logic [1:0]  e_qrdy;
    logic        e_qv;
    logic [2:0]  e_qid;
    logic [1:0]  e_pv;
    logic [2:0]  e_rid;
    logic        e_prdy;
    logic        e_err;
    logic [3:0]  e_out;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] qv, logic [2:0] qid0, logic [2:0] qid1,
                              logic qrdy, logic pv, logic [2:0] pid, logic [1:0] prdy,
                              logic [1:0] e_qrdy, logic e_qv, logic [2:0] e_qid, logic [1:0] e_pv,
                              logic [2:0] e_rid, logic e_prdy, logic e_err, logic [3:0] e_out);
    vec_t v;
    v.rst = rst; v.qv = qv; v.qid0 = qid0; v.qid1 = qid1; v.qrdy = qrdy;
    v.pv = pv; v.pid = pid; v.prdy = prdy;
    v.e_qrdy = e_qrdy; v.e_qv = e_qv; v.e_qid = e_qid; v.e_pv = e_pv;
    v.e_rid = e_rid; v.e_prdy = e_prdy; v.e_err = e_err; v.e_out = e_out;
    return v;
  endfunction

  vec_t vecs[16];

  // Reference model state (pool of meta IDs with owners)
  bit              m_alloc[MO];
  int              m_owner[MO];
  int              m_rid[MO];
  int              m_rr;
  bit              m_lock;
  int              m_lg, m_lid;
  bit              pend[N];
  logic [AW-1:0]   p_addr[N];
  logic [DW-1:0]   p_data[N];
  logic [RW-1:0]   p_qid[N];

  initial begin
    rst_i = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    //            rst qv    q0 q1 qr pv pid prdy   eqrdy eqv eqid epv  erid eprdy eerr eout
    vecs[0]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0);
    vecs[1]  = mk(0, 2'b01, 5, 0, 1, 0, 0, 2'b11, 2'b01, 1, 0, 2'b00, 0, 1, 0, 0);
    vecs[2]  = mk(0, 2'b00, 0, 0, 1, 1, 0, 2'b11, 2'b00, 0, 1, 2'b01, 5, 1, 0, 1);
    vecs[3]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 1, 0, 0);
    vecs[4]  = mk(1, 2'b11, 1, 2, 1, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    vecs[5]  = mk(0, 2'b11, 1, 2, 1, 0, 0, 2'b11, 2'b01, 1, 0, 2'b00, 0, 1, 0, 0);
    vecs[6]  = mk(0, 2'b11, 1, 2, 1, 0, 0, 2'b11, 2'b10, 1, 1, 2'b00, 0, 1, 0, 1);
    vecs[7]  = mk(0, 2'b11, 1, 2, 1, 0, 0, 2'b11, 2'b01, 1, 2, 2'b00, 0, 1, 0, 2);
    vecs[8]  = mk(0, 2'b11, 1, 2, 1, 0, 0, 2'b11, 2'b10, 1, 3, 2'b00, 0, 1, 0, 3);
    vecs[9]  = mk(0, 2'b00, 0, 0, 0, 1, 1, 2'b01, 2'b00, 0, 4, 2'b10, 2, 0, 0, 4);
    vecs[10] = mk(0, 2'b00, 0, 0, 0, 1, 1, 2'b11, 2'b00, 0, 4, 2'b10, 2, 1, 0, 4);
    vecs[11] = mk(0, 2'b00, 0, 0, 0, 1, 0, 2'b11, 2'b00, 0, 1, 2'b01, 1, 1, 0, 3);
    vecs[12] = mk(0, 2'b00, 0, 0, 0, 1, 6, 2'b11, 2'b00, 0, 0, 2'b00, 0, 1, 1, 2);
    vecs[13] = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 1, 0, 2);
    vecs[14] = mk(0, 2'b01, 4, 0, 1, 1, 2, 2'b11, 2'b01, 1, 0, 2'b01, 1, 1, 0, 2);
    vecs[15] = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 1, 2'b00, 0, 1, 0, 2);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_idle();
      rst_i = vecs[i].rst;
      set_req(0, vecs[i].qv[0], 32'h100, vecs[i].qid0);
      set_req(1, vecs[i].qv[1], 32'h200, vecs[i].qid1);
      out_qready_i = vecs[i].qrdy;
      set_rsp(vecs[i].pv, vecs[i].pid, vecs[i].prdy);
      #1;
      chk($sformatf("v%0d_qready", i), in_qready_o, vecs[i].e_qrdy);
      chk($sformatf("v%0d_qvalid", i), out_qvalid_o, vecs[i].e_qv);
      chk($sformatf("v%0d_qid", i), out_qid_o, vecs[i].e_qid);
      chk($sformatf("v%0d_pvalid", i), in_pvalid_o, vecs[i].e_pv);
      chk($sformatf("v%0d_pready", i), out_pready_o, vecs[i].e_prdy);
      chk($sformatf("v%0d_iderr", i), id_err_o, vecs[i].e_err);
      chk($sformatf("v%0d_outstanding", i), outstanding_o, vecs[i].e_out);
      if (vecs[i].e_qv) chk($sformatf("v%0d_qaddr", i), out_qaddr_o, vecs[i].e_qrdy[1] ? 32'h200 : 32'h100);
      if (vecs[i].e_pv[0]) chk($sformatf("v%0d_rid0", i), in_pid_o[0], vecs[i].e_rid);
      if (vecs[i].e_pv[1]) chk($sformatf("v%0d_rid1", i), in_pid_o[1], vecs[i].e_rid);
      if (vecs[i].e_pv != 0) chk($sformatf("v%0d_pdata", i), in_pdata_o[vecs[i].e_pv[1]], 32'hCAFE);
    end

    // Stall lock: grant and ID held while shim stalls, even though ID 0 frees meanwhile
    do_reset();
    @(negedge clk); drive_idle();
    set_req(0, 1, 32'h10, 3); out_qready_i = 1; #1;
    chk("lock_c1_qid", out_qid_o, 0); chk("lock_c1_qready", in_qready_o, 2'b01);
    @(negedge clk); drive_idle();
    set_req(1, 1, 32'h20, 6); out_qready_i = 0; #1;
    chk("lock_c2_qvalid", out_qvalid_o, 1); chk("lock_c2_qid", out_qid_o, 1);
    chk("lock_c2_addr", out_qaddr_o, 32'h20); chk("lock_c2_qready", in_qready_o, 2'b00);
    @(negedge clk);
    set_req(0, 1, 32'h30, 1); set_rsp(1, 0, 2'b11); #1;
    chk("lock_c3_qid", out_qid_o, 1); chk("lock_c3_addr", out_qaddr_o, 32'h20);
    chk("lock_c3_pvalid", in_pvalid_o, 2'b01);
    @(negedge clk);
    set_rsp(0, 0, 2'b11); #1;
    chk("lock_c4_qid", out_qid_o, 1); chk("lock_c4_addr", out_qaddr_o, 32'h20);
    chk("lock_c4_qready", in_qready_o, 2'b00);
    @(negedge clk);
    out_qready_i = 1; #1;
    chk("lock_c5_qready", in_qready_o, 2'b10); chk("lock_c5_qid", out_qid_o, 1);
    @(negedge clk);
    set_req(1, 0, 0, 0); #1;
    chk("lock_c6_qready", in_qready_o, 2'b01); chk("lock_c6_qid", out_qid_o, 0);
    chk("lock_c6_addr", out_qaddr_o, 32'h30);
    @(negedge clk); drive_idle(); #1;
    chk("lock_c7_outstanding", outstanding_o, 2);

    // Pool exhaustion and reuse of a freed ID one cycle later
    do_reset();
    for (int k = 0; k < MO; k++) begin
      @(negedge clk); drive_idle();
      set_req(0, 1, 32'h400 + k, 3'(k)); out_qready_i = 1; #1;
      chk($sformatf("exh_qid%0d", k), out_qid_o, k);
    end
    @(negedge clk);
    set_rsp(1, 3, 2'b11); #1;
    chk("exh_outstanding", outstanding_o, 8); chk("exh_qvalid", out_qvalid_o, 0);
    chk("exh_qready", in_qready_o, 2'b00); chk("exh_free_pvalid", in_pvalid_o, 2'b01);
    @(negedge clk);
    set_rsp(0, 0, 2'b11); #1;
    chk("exh_reuse_qvalid", out_qvalid_o, 1); chk("exh_reuse_qid", out_qid_o, 3);
    chk("exh_reuse_out", outstanding_o, 7);
    @(negedge clk); drive_idle(); #1;
    chk("exh_refill_out", outstanding_o, 8);

    // Reset with transactions in flight; abandoned ID later reports an error
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive_idle();
      set_req(1, 1, 32'h800, 3'(k)); out_qready_i = 1;
    end
    @(negedge clk); drive_idle(); #1;
    chk("rst_pre_out", outstanding_o, 4);
    @(negedge clk);
    rst_i = 1; set_req(0, 1, 32'h900, 1); out_qready_i = 1; set_rsp(1, 1, 2'b11); #1;
    chk("rst_qready", in_qready_o, 2'b00); chk("rst_pready", out_pready_o, 0);
    chk("rst_qvalid", out_qvalid_o, 0); chk("rst_pvalid", in_pvalid_o, 2'b00);
    @(negedge clk);
    rst_i = 0; set_rsp(0, 0, 2'b11); #1;
    chk("rst_post_out", outstanding_o, 0); chk("rst_post_qid", out_qid_o, 0);
    chk("rst_post_qready", in_qready_o, 2'b01);
    @(negedge clk); drive_idle();
    set_rsp(1, 2, 2'b11); #1;
    chk("rst_err", id_err_o, 1); chk("rst_err_pready", out_pready_o, 1);
    chk("rst_err_pvalid", in_pvalid_o, 2'b00);
    @(negedge clk); set_rsp(0, 2, 2'b11); #1;
    chk("rst_err_pulse", id_err_o, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < MO; k++) m_alloc[k] = 0;
    m_rr = 0; m_lock = 0;
    for (int r = 0; r < N; r++) pend[r] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int nalloc, free_id, g, id, pid, o;
      bit ev, hs, rsp_hs, found;
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r]   = 1;
          p_addr[r] = $urandom;
          p_data[r] = $urandom;
          p_qid[r]  = RW'($urandom_range(0, 7));
        end
        in_qvalid_i[r] = pend[r];
        in_qaddr_i[r]  = p_addr[r];
        in_qdata_i[r]  = p_data[r];
        in_qid_i[r]    = p_qid[r];
      end
      out_qready_i = ($urandom_range(0, 3) != 0);
      out_pvalid_i = ($urandom_range(0, 1) == 1);
      pid = $urandom_range(0, MO - 1);
      if ($urandom_range(0, 3) != 0) begin
        found = 0;
        for (int t = 0; t < MO; t++)
          if (!found && m_alloc[(pid + t) % MO]) begin pid = (pid + t) % MO; found = 1; end
      end
      out_pid_i   = MW'(pid);
      out_pdata_i = $urandom;
      in_pready_i = N'($urandom_range(0, 3));
      #1;
      nalloc = 0; free_id = -1;
      for (int k = 0; k < MO; k++)
        if (m_alloc[k]) nalloc++;
        else if (free_id < 0) free_id = k;
      chk("rnd_outstanding", outstanding_o, nalloc);
      if (m_lock) begin
        g = m_lg; id = m_lid; ev = 1;
      end else begin
        g = -1;
        for (int t = 0; t < N; t++) if (g < 0 && pend[(m_rr + t) % N]) g = (m_rr + t) % N;
        ev = (g >= 0) && (free_id >= 0);
        id = free_id;
      end
      chk("rnd_qvalid", out_qvalid_o, ev);
      if (ev) begin
        chk("rnd_qid", out_qid_o, id);
        chk("rnd_qready", in_qready_o, out_qready_i ? (1 << g) : 0);
        if (out_qready_i) exp_q.push_back({p_addr[g], p_data[g]});
      end else begin
        chk("rnd_qready_idle", in_qready_o, 0);
      end
      if (out_qvalid_o && out_qready_i) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rnd_sb @%0t: got unexpected request addr 0x%0h expected none", $time, out_qaddr_o);
        end else begin
          chk("rnd_sb_payload", {out_qaddr_o, out_qdata_o}, exp_q.pop_front());
        end
      end
      rsp_hs = 0;
      if (out_pvalid_i) begin
        if (m_alloc[pid]) begin
          o = m_owner[pid];
          chk("rnd_pvalid", in_pvalid_o, 1 << o);
          chk("rnd_rid", in_pid_o[o], m_rid[pid]);
          chk("rnd_pdata", in_pdata_o[o], out_pdata_i);
          chk("rnd_pready", out_pready_o, in_pready_i[o]);
          chk("rnd_noerr", id_err_o, 0);
          rsp_hs = in_pready_i[o];
        end else begin
          chk("rnd_pvalid_bad", in_pvalid_o, 0);
          chk("rnd_pready_bad", out_pready_o, 1);
          chk("rnd_err", id_err_o, 1);
        end
      end else begin
        chk("rnd_pvalid_idle", in_pvalid_o, 0);
        chk("rnd_err_idle", id_err_o, 0);
      end
      hs = ev && out_qready_i;
      if (hs) begin
        m_alloc[id] = 1; m_owner[id] = g; m_rid[id] = p_qid[g];
        m_rr = (g + 1) % N; m_lock = 0; pend[g] = 0;
      end else if (ev) begin
        m_lock = 1; m_lg = g; m_lid = id;
      end
      if (rsp_hs) m_alloc[pid] = 0;
    end
    chk("rnd_sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
